// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 64-bit data memory.
// Each granted request occupies one ACCESS cycle; completion pulses the cycle after.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                lat_write_q, lat_write_d;
    logic                lat_port_q, lat_port_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                grant_any;
    logic                grant_port;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On conflict the port not served last wins; a lone requester always wins.
    always_comb begin
        grant_any = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_port = ~last_grant_q;
        end else begin
            grant_port = req1_valid;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        last_grant_d = last_grant_q;
        lat_write_d  = lat_write_q;
        lat_port_d   = lat_port_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        if (grant_any) begin
            last_grant_d = grant_port;
            lat_port_d   = grant_port;
            lat_write_d  = grant_port ? req1_write : req0_write;
            lat_addr_d   = grant_port ? req1_addr  : req0_addr;
            lat_wdata_d  = grant_port ? req1_wdata : req0_wdata;
        end

        done0_d = (state_q == ACCESS) && !lat_port_q;
        done1_d = (state_q == ACCESS) &&  lat_port_q;

        if ((state_q == ACCESS) && !lat_write_q) begin
            if (lat_port_q) rdata1_d = mem_read_data;
            else            rdata0_d = mem_read_data;
        end
    end

    // NOTE: the rdata holding registers are reset too, so a port reads 0 before its first load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            lat_write_q  <= 1'b0;
            lat_port_q   <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lat_write_q  <= lat_write_d;
            lat_port_q   <= lat_port_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        req0_ready     = grant_any && !grant_port;
        req1_ready     = grant_any &&  grant_port;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (state_q == ACCESS) begin
            mem_read       = !lat_write_q;
            mem_write      =  lat_write_q;
            mem_address    = lat_addr_q;
            mem_write_data = lat_wdata_q;
        end
    end

    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, a timestamped transaction model
// compared every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req0_write, req0_ready, req0_done;
    logic [63:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_done;
    logic [63:0] req1_addr, req1_wdata, req1_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] init_val(input int i);
        if (i == 2) return 64'h1234;
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: 128 doublewords, combinational read, write on the rising edge.
    logic [63:0] mem [128];
    logic        mem_loaded = 1'b0;
    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[9:3]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_address[9:3]];

    // Transaction model: a grant at cycle n schedules the access at n+1 and the
    // completion at n+2; the arbiter is free again from n+2.
    logic [63:0] ref_mem [128];
    logic [63:0] ref_rdata [2];
    bit          model_init = 1'b0;
    int          n = 0;
    int          free_at = 0;
    bit          acc_pend, acc_port, acc_wr;
    int          acc_at;
    logic [63:0] acc_addr, acc_wd;
    bit          done_pend, done_port, done_wr;
    int          done_at;
    logic [63:0] done_data;
    bit          last_served = 1'b1;
    bit          e_r0, e_r1, e_d0, e_d1, e_mr, e_mw, w;
    logic [63:0] e_ma, e_md;

    always @(negedge clock) begin
        if (!model_init) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
            model_init = 1'b1;
        end
        e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; e_mr = 0; e_mw = 0;
        e_ma = '0; e_md = '0;
        if (reset) begin
            acc_pend = 0; done_pend = 0; last_served = 1; free_at = 0;
            ref_rdata[0] = '0; ref_rdata[1] = '0;
        end else begin
            if (done_pend && done_at == n) begin
                done_pend = 0;
                if (done_port) e_d1 = 1; else e_d0 = 1;
                if (!done_wr) ref_rdata[done_port] = done_data;
            end
            if (acc_pend && acc_at == n) begin
                acc_pend = 0;
                e_mr = !acc_wr; e_mw = acc_wr; e_ma = acc_addr; e_md = acc_wd;
                if (acc_wr) ref_mem[acc_addr[9:3]] = acc_wd;
                else        done_data = ref_mem[acc_addr[9:3]];
                done_pend = 1; done_at = n + 1; done_port = acc_port; done_wr = acc_wr;
            end
            if (n >= free_at && (req0_valid || req1_valid)) begin
                w = (req0_valid && req1_valid) ? !last_served : req1_valid;
                if (w) e_r1 = 1; else e_r0 = 1;
                last_served = w;
                acc_pend = 1; acc_at = n + 1; acc_port = w;
                acc_wr   = w ? req1_write : req0_write;
                acc_addr = w ? req1_addr  : req0_addr;
                acc_wd   = w ? req1_wdata : req0_wdata;
                free_at  = n + 2;
            end
        end
        check("m_ready0", req0_ready, e_r0);
        check("m_ready1", req1_ready, e_r1);
        check("m_done0", req0_done, e_d0);
        check("m_done1", req1_done, e_d1);
        check("m_rdata0", req0_rdata, ref_rdata[0]);
        check("m_rdata1", req1_rdata, ref_rdata[1]);
        check("m_mem_read", mem_read, e_mr);
        check("m_mem_write", mem_write, e_mw);
        check("m_mem_address", mem_address, e_ma);
        check("m_mem_wdata", mem_write_data, e_md);
        n++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        repeat (3) tick;
        #2;
        check("rst_ready0", req0_ready, 0);
        check("rst_done1", req1_done, 0);
        check("rst_rdata0", req0_rdata, 0);
        check("rst_mem_read", mem_read, 0);
        reset = 1'b0;
        tick;

        // Single load from port 0.
        req0_valid = 1; req0_write = 0; req0_addr = 64'h10;
        #2 check("load_ready", req0_ready, 1);
        tick; req0_valid = 0;
        #2 check("load_mem_read", mem_read, 1);
        check("load_mem_addr", mem_address, 64'h10);
        tick;
        #2 check("load_done", req0_done, 1);
        check("load_rdata", req0_rdata, 64'h1234);
        tick;

        // Store then load on port 1; the load is granted in the store's done cycle.
        req1_valid = 1; req1_write = 1; req1_addr = 64'h18; req1_wdata = 64'hCAFE_BABE;
        #2 check("st_ready", req1_ready, 1);
        tick; req1_valid = 0;
        #2 check("st_mem_write", mem_write, 1);
        check("st_mem_wdata", mem_write_data, 64'hCAFE_BABE);
        tick;
        #2 check("st_write_pulse", mem_write, 0);
        check("st_done", req1_done, 1);
        check("st_rdata_kept", req1_rdata, 64'h0);
        req1_valid = 1; req1_write = 0;
        #1 check("ld_ready", req1_ready, 1);
        tick; req1_valid = 0;
        #2 check("ld_mem_read", mem_read, 1);
        tick;
        #2 check("ld_done", req1_done, 1);
        check("ld_rdata", req1_rdata, 64'hCAFE_BABE);
        tick;

        // Back-to-back loads on port 0 with valid held.
        req0_valid = 1; req0_write = 0;
        for (int i = 0; i < 3; i++) begin
            req0_addr = 64'(i * 8);
            #2 check("b2b_ready", req0_ready, 1);
            if (i > 0) begin
                check("b2b_done", req0_done, 1);
                check("b2b_rdata", req0_rdata, init_val(i - 1));
            end
            tick;
            if (i == 2) req0_valid = 0;
            #2 check("b2b_busy", req0_ready, 0);
            tick;
        end
        #2 check("b2b_done_last", req0_done, 1);
        check("b2b_rdata_last", req0_rdata, 64'h1234);
        tick;

        // Continuous conflict right after reset: port 0 first, then alternate.
        reset = 1;
        tick;
        reset = 0;
        req0_valid = 1; req0_write = 0; req0_addr = 64'h0;
        req1_valid = 1; req1_write = 0; req1_addr = 64'h8;
        #2 check("cf_first0", req0_ready, 1);
        check("cf_first1", req1_ready, 0);
        tick; tick;
        #2 check("cf_second1", req1_ready, 1);
        check("cf_second0", req0_ready, 0);
        check("cf_done0", req0_done, 1);
        tick; tick;
        #2 check("cf_third0", req0_ready, 1);
        check("cf_done1", req1_done, 1);
        check("cf_rdata1", req1_rdata, init_val(1));
        tick; tick;
        #2 check("cf_fourth1", req1_ready, 1);
        req0_valid = 0; req1_valid = 0;
        tick; tick; tick;

        // Withdrawal: port 1 asserts valid only while port 0 is in ACCESS.
        req0_valid = 1; req0_write = 0; req0_addr = 64'h8;
        #2 check("wd_ready0", req0_ready, 1);
        tick; req0_valid = 0;
        req1_valid = 1; req1_write = 1; req1_addr = 64'h20; req1_wdata = 64'h55;
        #2 check("wd_no_ready1", req1_ready, 0);
        tick; req1_valid = 0;
        #2 check("wd_done0", req0_done, 1);
        check("wd_no_done1", req1_done, 0);
        tick;
        #2 check("wd_no_mem_write", mem_write, 0);
        check("wd_no_done1_late", req1_done, 0);
        tick;

        // Reset in the middle of a store ACCESS: the store must not commit.
        req0_valid = 1; req0_write = 1; req0_addr = 64'h10; req0_wdata = 64'hDEAD;
        #2 check("rs_ready", req0_ready, 1);
        tick; req0_valid = 0;
        #1 check("rs_in_access", mem_write, 1);
        reset = 1; req1_valid = 1; req1_write = 0; req1_addr = 64'h0;
        #1 check("rs_write_drop", mem_write, 0);
        check("rs_addr_zero", mem_address, 0);
        check("rs_ready_gated", req1_ready, 0);
        tick;
        #2 check("rs_hold_ready", req1_ready, 0);
        check("rs_hold_wdata", mem_write_data, 0);
        req1_valid = 0; reset = 0;
        tick;
        req0_valid = 1; req0_write = 0; req0_addr = 64'h10;
        #2 check("rs_ld_ready", req0_ready, 1);
        tick; req0_valid = 0;
        tick;
        #2 check("rs_ld_done", req0_done, 1);
        check("rs_ld_rdata", req0_rdata, 64'h1234);
        tick; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the shared 64-bit data memory (128 doublewords, combinational read, write committed on the rising clock edge). It accepts load/store requests from port 0 (CPU memory stage) and port 1 (debug/loader). It serializes them with round-robin priority and drives the memory's `mem_read`/`mem_write`/`address`/`write_data` pins for exactly one cycle per access. Read data is returned in a register with a completion pulse.

## Interface
Parameters:
- `ADDR_W`, 64, request/memory address width
- `DATA_W`, 64, data width

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  port 0 request present
- `req0_write`  in  1  1 = store, 0 = load
- `req0_addr`  in  ADDR_W  byte address
- `req0_wdata`  in  DATA_W  store data
- `req0_ready`  out  1  request accepted this cycle (combinational)
- `req0_done`  out  1  one-cycle completion pulse
- `req0_rdata`  out  DATA_W  load result, valid while `req0_done`=1 for a load
- `req1_*`  same set of signals for port 1
- `mem_read`  out  1  to memory `mem_read`
- `mem_write`  out  1  to memory `mem_write`
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_write_data`  out  DATA_W  to memory `write_data`
- `mem_read_data`  in  DATA_W  from memory `read_data`

## Operation
- FSM states are IDLE and ACCESS.
- **IDLE:**
  - If any `reqN_valid` is set, select a winner, assert its `reqN_ready`, latch `write`/`addr`/`wdata`/port id, then move to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS:**
  - Drive `mem_address`/`mem_write_data` from the latched registers.
  - For a store, `mem_write`=1. For a load, `mem_read`=1.
  - At the rising edge: a load captures `mem_read_data` into the winner's `rdata` register, and a store commits in memory.
  - Move to IDLE and raise the winner's `done` for the next cycle.
- **Round-robin:**
  - The `last_grant` register holds the port served last.
  - On a conflict, the port ≠ `last_grant` wins.
  - A single requester always wins.
  - `last_grant` updates on every grant.
- In the IDLE cycle where `done` pulses, a new request may be granted, so the next access follows back-to-back.
- **Outputs outside ACCESS:**
  - `mem_read`=`mem_write`=0.
  - `mem_address`/`mem_write_data` = 0.
- **`rdata` behaviour:**
  - `reqN_rdata` holds its last load value until the next load on that port.
  - Stores do not modify `rdata`.
- Addresses are passed through unmodified. The memory uses `address[ADDR_W-1:3]`, and the arbiter does not check alignment or range.
- Requesters hold `valid`/`write`/`addr`/`wdata` stable until `ready`. Dropping `valid` before `ready` withdraws the request.
- **Reset (asynchronous, any state):**
  - State returns to IDLE, with `mem_read`/`mem_write` forced to 0 immediately, so a store in ACCESS is aborted and not committed.
  - `last_grant`=1, so port 0 wins the first conflict.
  - `ready`=0, `done`=0, all `rdata`=0, latched request registers 0.

## Timing
- Grant is combinational in IDLE: `reqN_ready` is high in the same cycle as `reqN_valid` when that port wins.
- Latency from `ready` cycle T:
  - Memory access happens in T+1.
  - `done` (and `rdata` for a load) is valid in T+2.
- Throughput is one access per 2 cycles, with 50% sustained bandwidth under continuous requests.
- A loser's `ready` stays 0. It is granted in the T+2 IDLE cycle if still valid.
- `done` is exactly one cycle wide and never asserted on both ports in the same cycle.
- A load in ACCESS that immediately follows a store to the same address returns the new data, because the write committed at the previous edge.

## Test plan
- **Reset:** assert `reset` mid-ACCESS of a store of 0xDEAD to addr 0x10.
  - Required: `mem_write` drops immediately.
  - Required: a later load of 0x10 returns the pre-reset value.
  - Required: all outputs are 0 during reset.
- **Single load:** memory[2]=0x1234. Port 0 loads addr 0x10.
  - Required: `ready` at T.
  - Required: `mem_read`=1 and `mem_address`=0x10 at T+1.
  - Required: `req0_done`=1 and `req0_rdata`=0x1234 at T+2.
- **Store then load:** port 1 stores 0xCAFEBABE to addr 0x18, then loads 0x18.
  - Required: `mem_write` pulses for 1 cycle.
  - Required: the load returns 0xCAFEBABE.
  - Required: `req1_rdata` is unchanged after the store.
- **Conflict after reset:** both ports request loads continuously.
  - Required: grants alternate 0,1,0,1 at 2-cycle spacing.
  - Required: `done` pulses alternate ports on consecutive even cycles.
- **Back-to-back:** port 0 holds `valid` for 3 loads (addr 0x0, 0x8, 0x10).
  - Required: `ready` at T, T+2, T+4.
  - Required: `done` at T+2, T+4, T+6, each with correct data.
- **Withdrawal:** port 1 raises `valid` while port 0's access is in ACCESS, then drops it before IDLE.
  - Required: no grant, no memory activity, no `req1_done`.
